ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative RV32M multiply/divide unit alongside the single-cycle execute stage. Accepts one M-op
//  (funct7=0000001, opcode INST_TYPE_R), computes it over several cycles with a shift-add multiplier or
//  restoring divider, holds ctrl stalled via busy_o, then issues a one-cycle register writeback.
// PARAMETERS
//  XLEN        32  operand/result width (>=8, power of 2)
//  REG_ADDR_W  5   destination register address width
//  (local) CNT_W = $clog2(XLEN)+1  iteration counter width
// PORTS
//  clk           in   1           clock, all state on rising edge
//  arst_n        in   1           reset, synchronous, active-low
//  start_i       in   1           op valid from execute; accepted only when ready_o=1
//  funct3_i      in   3           000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op1_i         in   XLEN        rs1 value (multiplicand / dividend)
//  op2_i         in   XLEN        rs2 value (multiplier / divisor)
//  reg_w_addr_i  in   REG_ADDR_W  destination register
//  flush_i       in   1           abort in-flight op (jump taken / pipeline flush)
//  ready_o       out  1           unit idle, start_i will be accepted
//  busy_o        out  1           op in flight; ctrl stalls the pipeline
//  done_o        out  1           one-cycle pulse, result valid
//  reg_w_ena_o   out  1           writeback enable (= done_o)
//  reg_w_addr_o  out  REG_ADDR_W  latched destination register
//  reg_w_data_o  out  XLEN        result, 0 when done_o=0
// BEHAVIOUR
//  Reset (arst_n=0 at edge): state IDLE, counter/accumulators 0; ready_o=1, busy_o=0, done_o=0,
//   reg_w_ena_o=0, reg_w_addr_o=0, reg_w_data_o=0. Reset mid-op discards the op, no done_o.
//  FSM: IDLE -start_i-> CALC (XLEN cycles) -> FIX (1) -> DONE (1) -> IDLE. ready_o=(IDLE), busy_o=!IDLE.
//  Latency: accept cycle = 0; CALC cycles 1..XLEN; FIX XLEN+1; done_o high in cycle XLEN+2 only.
//  Accept latches funct3, reg_w_addr, |op1|,|op2| (abs per op signedness) and result-sign flags.
//   Signed: MULH both, MULHSU op1 only, DIV/REM both; MUL uses low half (sign-agnostic).
//  CALC mul: 2*XLEN accumulator, one multiplier bit per cycle (LSB first).
//  CALC div: one restoring step per cycle, MSB first, quotient and remainder XLEN bits each.
//  FIX: negate product if sign(op1)^sign(op2); quotient same rule; remainder takes dividend sign.
//   Select: MUL low XLEN, MULH/MULHSU/MULHU high XLEN, DIV/DIVU quotient, REM/REMU remainder.
//  Divide by zero: quotient = all ones, remainder = op1 (signed and unsigned).
//  Overflow DIV: op1=-2^(XLEN-1), op2=-1 -> quotient=op1, remainder=0.
//  start_i while busy_o=1: ignored, no state change (ctrl must hold the op).
//  flush_i in any non-IDLE state: next state IDLE, no done_o; flush_i with start_i in IDLE: start dropped.
//  flush_i in DONE cycle: done_o of that cycle still stands (writeback already committed).
//  Counter wraps never: CALC exits when counter reaches XLEN-1, cleared on accept.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: divide-by-zero, DIV overflow and any multiply with op1=0 or op2=0
//   go IDLE->DONE directly; done_o in cycle 1 after accept. All other ops unchanged.
//  Not defined: every op takes the full XLEN+2 latency; results identical either way.
// STRUCTURE
//  Shared define.v gains: `INST_MUL..`INST_REMU funct3 codes, `FUNCT7_MULDIV, MULDIV FSM state codes
//   (IDLE/CALC/FIX/DONE, 2-bit).
//  One sub-module: ex_muldiv_divstep (combinational restoring step: partial rem, divisor -> next rem,
//   quotient bit); multiplier step stays inline.
// TESTING (XLEN=32, macro undefined unless noted)
//  MUL 7 * -3 (0xFFFFFFFD) -> done_o in cycle 34, reg_w_data_o=0xFFFFFFEB, reg_w_addr_o=latched rd.
//  0xFFFFFFFF,0xFFFFFFFF: MULHU->0xFFFFFFFE, MULH->0x00000000, MULHSU->0xFFFFFFFF.
//  DIV -7/2->0xFFFFFFFD, REM->0xFFFFFFFF; DIVU 100/7->14, REMU->2.
//  DIV 5/0->0xFFFFFFFF, REM 5/0->5; DIV 0x80000000/-1->0x80000000, REM->0; with macro: done cycle 1.
//  flush_i in cycle 10 -> busy_o=0 in cycle 11, no done_o; start_i in cycle 11 accepted, normal result.
//  start_i pulsed in cycle 5 while busy -> ignored; arst_n=0 in cycle 20 -> all outputs reset values.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, the M-extension funct7 tag and the FSM state type.
package ex_muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [6:0] INST_TYPE_R   = 7'b0110011;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module ex_muldiv_divstep
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic            qbit_o
);

  logic [XLEN:0]   part_s;
  logic [XLEN-1:0] diff_s;

  // Trial subtraction; the low XLEN bits of the difference are exact whenever it fits.
  always_comb begin
    part_s = {rem_i, bit_i};
    diff_s = part_s[XLEN-1:0] - div_i;
    qbit_o = (part_s >= {1'b0, div_i});
    if (qbit_o) begin
      rem_o = diff_s;
    end else begin
      rem_o = part_s[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// accept, processed one bit per cycle, then sign-corrected in a FIX cycle.
// Optional feature macro: MULDIV_EARLY_OUT_EN (trivial ops skip straight to DONE).
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [XLEN-1:0]       op1_i,
  input  logic [XLEN-1:0]       op2_i,
  input  logic [REG_ADDR_W-1:0] reg_w_addr_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  reg_w_ena_o,
  output logic [REG_ADDR_W-1:0] reg_w_addr_o,
  output logic [XLEN-1:0]       reg_w_data_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       opnd_q, opnd_d;     // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0]     acc_q, acc_d;       // mul: {hi, multiplier}; div: {rem, dividend/quotient}
  logic                  neg_q, neg_d;       // negate product / quotient
  logic                  rneg_q, rneg_d;     // negate remainder
  logic                  dz_q, dz_d;         // divide by zero
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [XLEN-1:0]       data_q, data_d;

  logic                  op1_neg_s, op2_neg_s;
  logic [XLEN-1:0]       abs1_s, abs2_s;
  logic [XLEN:0]         mul_sum_s;
  logic [2*XLEN-1:0]     mul_next_s, div_next_s;
  logic [XLEN-1:0]       ds_rem_s;
  logic                  ds_qbit_s;
  logic [2*XLEN-1:0]     prod_s;
  logic [XLEN-1:0]       quo_s, rem_s, fix_data_s;
  logic                  early_hit_s;
  logic [XLEN-1:0]       early_data_s;

  ex_muldiv_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_i  (acc_q[2*XLEN-1:XLEN]),
    .bit_i  (acc_q[XLEN-1]),
    .div_i  (opnd_q),
    .rem_o  (ds_rem_s),
    .qbit_o (ds_qbit_s)
  );

  // Operand signedness and magnitudes at accept time.
  always_comb begin
    op1_neg_s = op1_i[XLEN-1] & ((funct3_i == INST_MULH) | (funct3_i == INST_MULHSU) |
                                 (funct3_i == INST_DIV)  | (funct3_i == INST_REM));
    op2_neg_s = op2_i[XLEN-1] & ((funct3_i == INST_MULH) | (funct3_i == INST_DIV) |
                                 (funct3_i == INST_REM));
    abs1_s = op1_neg_s ? ({XLEN{1'b0}} - op1_i) : op1_i;
    abs2_s = op2_neg_s ? ({XLEN{1'b0}} - op2_i) : op2_i;
  end

  // Per-cycle shift-add multiply step and restoring divide step.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                 (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};
    div_next_s = {ds_rem_s, acc_q[XLEN-2:0], ds_qbit_s};
  end

  // Sign correction and result selection in the FIX cycle.
  always_comb begin
    prod_s = neg_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
    if (dz_q) begin
      quo_s = {XLEN{1'b1}};
    end else if (neg_q) begin
      quo_s = {XLEN{1'b0}} - acc_q[XLEN-1:0];
    end else begin
      quo_s = acc_q[XLEN-1:0];
    end
    rem_s = rneg_q ? ({XLEN{1'b0}} - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    case (funct3_q)
      INST_MUL:                           fix_data_s = prod_s[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: fix_data_s = prod_s[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:                fix_data_s = quo_s;
      INST_REM, INST_REMU:                fix_data_s = rem_s;
      default:                            fix_data_s = {XLEN{1'b0}};
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic dz_in_s, ovf_in_s;

  // Detect ops whose result is known at accept and produce it directly.
  always_comb begin
    early_hit_s  = 1'b0;
    early_data_s = {XLEN{1'b0}};
    dz_in_s  = (op2_i == {XLEN{1'b0}});
    ovf_in_s = ((funct3_i == INST_DIV) | (funct3_i == INST_REM)) &
               (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == {XLEN{1'b1}});
    if (is_div(funct3_i)) begin
      if (dz_in_s) begin
        early_hit_s  = 1'b1;
        early_data_s = funct3_i[1] ? op1_i : {XLEN{1'b1}};
      end else if (ovf_in_s) begin
        early_hit_s  = 1'b1;
        early_data_s = funct3_i[1] ? {XLEN{1'b0}} : op1_i;
      end else begin
        early_hit_s  = 1'b0;
      end
    end else begin
      if ((op1_i == {XLEN{1'b0}}) | (op2_i == {XLEN{1'b0}})) begin
        early_hit_s = 1'b1;
      end else begin
        early_hit_s = 1'b0;
      end
    end
  end
`else
  assign early_hit_s  = 1'b0;
  assign early_data_s = {XLEN{1'b0}};
`endif

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          funct3_d = funct3_i;
          rd_d     = reg_w_addr_i;
          cnt_d    = {CNT_W{1'b0}};
          neg_d    = op1_neg_s ^ op2_neg_s;
          rneg_d   = op1_neg_s;
          dz_d     = is_div(funct3_i) & (op2_i == {XLEN{1'b0}});
          if (is_div(funct3_i)) begin
            opnd_d = abs2_s;
            acc_d  = {{XLEN{1'b0}}, abs1_s};
          end else begin
            opnd_d = abs1_s;
            acc_d  = {{XLEN{1'b0}}, abs2_s};
          end
          state_d = early_hit_s ? MD_DONE : MD_CALC;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (flush_i) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = is_div(funct3_q) ? div_next_s : mul_next_s;
          if (cnt_q == CNT_LAST) begin
            state_d = MD_FIX;
          end else begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = MD_CALC;
          end
        end
      end
      MD_FIX:  state_d = flush_i ? MD_IDLE : MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase

    ready_d = (state_d == MD_IDLE);
    busy_d  = !ready_d;
    done_d  = (state_d == MD_DONE);
    if (!done_d) begin
      data_d = {XLEN{1'b0}};
    end else if (state_q == MD_IDLE) begin
      data_d = early_data_s;
    end else begin
      data_d = fix_data_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      funct3_q <= 3'b000;
      rd_q     <= {REG_ADDR_W{1'b0}};
      opnd_q   <= {XLEN{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
    end
  end

  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign reg_w_ena_o  = done_q;
  assign reg_w_addr_o = rd_q;
  assign reg_w_data_o = data_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=32): directed spec cases, control
// scenarios (busy start, flush, reset) and randomized ops against a 64-bit
// arithmetic reference model. Honors MULDIV_EARLY_OUT_EN for latency.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        ready_o, busy_o, done_o, reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  ex_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .start_i      (start_i),
    .funct3_i     (funct3_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .reg_w_addr_i (rd_i),
    .flush_i      (flush_i),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .reg_w_ena_o  (reg_w_ena_o),
    .reg_w_addr_o (reg_w_addr_o),
    .reg_w_data_o (reg_w_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        q = longint'(ua / ub); return q[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        q = longint'(ua % ub); return q[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    bit early;
    if (f3[2]) early = (b == 32'd0) ||
                       ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
    else       early = (a == 32'd0) || (b == 32'd0);
    return early ? 1 : 34;
`else
    return 34;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    funct3_i = f3; op1_i = a; op2_i = b; rd_i = rd; start_i = 1'b1;
    cyc = 0;
    tick();
    start_i  = 1'b0;
    funct3_i = 3'($urandom);
    op1_i    = $urandom;
    op2_i    = $urandom;
    rd_i     = 5'($urandom);
  endtask

  task automatic wait_done();
    while (!done_o && cyc < 80) tick();
  endtask

  task automatic finish_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    wait_done();
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat(f3, a, b)));
    check({tag, "_data"}, 64'(reg_w_data_o), 64'(exp));
    check({tag, "_addr"}, 64'(reg_w_addr_o), 64'(rd));
    check({tag, "_ena"}, 64'(reg_w_ena_o), 64'd1);
    tick();
    check({tag, "_after_done"}, {62'd0, done_o, ready_o}, 64'd1);
    check({tag, "_after_data"}, 64'(reg_w_data_o), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    start_op(f3, a, b, rd);
    finish_op(tag, f3, a, b, rd, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir_vecs[13];
  int   done_cnt;

  initial begin
    dir_vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    dir_vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    dir_vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    dir_vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    dir_vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    dir_vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    dir_vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14};
    dir_vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2};
    dir_vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF};
    dir_vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5};
    dir_vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    dir_vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
    dir_vecs[12] = '{3'd0, 32'd0,        32'd12345,    32'd0};

    arst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'd0; op1_i = 32'd0; op2_i = 32'd0; rd_i = 5'd0;
    repeat (3) tick();
    check("reset_flags", {60'd0, ready_o, busy_o, done_o, reg_w_ena_o}, 64'b1000);
    check("reset_addr", 64'(reg_w_addr_o), 64'd0);
    check("reset_data", 64'(reg_w_data_o), 64'd0);
    arst_n = 1'b1;
    tick();

    // Directed cases from the specification.
    foreach (dir_vecs[i])
      run_op($sformatf("dir%0d", i), dir_vecs[i].f3, dir_vecs[i].a, dir_vecs[i].b,
             5'(i + 1), dir_vecs[i].exp);

    // start_i pulsed in cycle 5 while busy is ignored.
    start_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd3);
    check("busy_c1", {62'd0, busy_o, ready_o}, 64'b10);
    while (cyc < 5) tick();
    funct3_i = 3'd5; op1_i = 32'd100; op2_i = 32'd7; rd_i = 5'd20; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    finish_op("busy_start", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB);

    // flush_i in cycle 10 aborts; a new op starting in cycle 11 runs normally.
    start_op(3'd5, 32'd100, 32'd7, 5'd7);
    while (cyc < 10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_c11", {61'd0, busy_o, ready_o, done_o}, 64'b010);
    run_op("after_flush", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14);

    // flush_i during the DONE cycle keeps that cycle's writeback.
    start_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
    wait_done();
    flush_i = 1'b1;
    #1;
    check("flush_done_pulse", 64'(done_o), 64'd1);
    check("flush_done_data", 64'(reg_w_data_o), 64'hFFFFFFFD);
    tick();
    flush_i = 1'b0;
    check("flush_done_after", {62'd0, ready_o, done_o}, 64'b10);

    // flush_i together with start_i in IDLE drops the start.
    funct3_i = 3'd0; op1_i = 32'd3; op2_i = 32'd4; rd_i = 5'd11;
    start_i = 1'b1; flush_i = 1'b1;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_idle", {62'd0, busy_o, ready_o}, 64'b01);
    done_cnt = 0;
    repeat (40) begin tick(); if (done_o) done_cnt++; end
    check("flush_start_no_done", 64'(done_cnt), 64'd0);

    // Reset in cycle 20 discards the op.
    start_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12);
    while (cyc < 20) tick();
    arst_n = 1'b0;
    tick();
    check("midreset_flags", {60'd0, ready_o, busy_o, done_o, reg_w_ena_o}, 64'b1000);
    check("midreset_addr", 64'(reg_w_addr_o), 64'd0);
    check("midreset_data", 64'(reg_w_data_o), 64'd0);
    arst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin tick(); if (done_o) done_cnt++; end
    check("midreset_no_done", 64'(done_cnt), 64'd0);

    // Randomized ops against the reference model.
    for (int k = 0; k < 60; k++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom);
      run_op($sformatf("rnd%0d_f%0d", k, f3), f3, a, b, rd, ref_model(f3, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
